// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: widths, dout field offsets,
// divide-by-zero quotient and FSM state encodings.
package div_ctrl_pkg;
  localparam int DATA_W   = 32;
  localparam int DOUT_W   = 2*DATA_W;
  localparam int QUOT_MSB = DOUT_W-1;
  localparam int QUOT_LSB = DATA_W;
  localparam int REM_MSB  = DATA_W-1;
  localparam int REM_LSB  = 0;

  localparam logic [DATA_W-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate of a value pair: abs() on operands,
// sign restore on quotient/remainder.
module div_sign_fix import div_ctrl_pkg::*; (
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              hi_neg,
  input  logic              lo_neg,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  assign hi_o = hi_neg ? -hi_i : hi_i;
  assign lo_o = lo_neg ? -lo_i : lo_i;
endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide controller in front of an unsigned AXI-Stream divider IP.
// Optional last-result cache enabled by defining DIV_CACHE_EN.
module div_ctrl import div_ctrl_pkg::*; (
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_req_valid,
  output logic              div_req_ready,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_a,
  input  logic [DATA_W-1:0] div_b,
  input  logic              flush,
  output logic              div_busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_quot,
  output logic [DATA_W-1:0] res_rem,
  output logic [DATA_W-1:0] dividend_tdata,
  output logic              dividend_tvalid,
  input  logic              dividend_tready,
  output logic [DATA_W-1:0] divisor_tdata,
  output logic              divisor_tvalid,
  input  logic              divisor_tready,
  input  logic [DOUT_W-1:0] dout_tdata,
  input  logic              dout_tvalid
);
  div_state_e state_q, state_d;
  logic kill_q, kill_d, dvd_vld_q, dvd_vld_d, dvs_vld_q, dvs_vld_d;
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, res_vld_q, res_vld_d;
  logic [DATA_W-1:0] dvd_data_q, dvd_data_d, dvs_data_q, dvs_data_d;
  logic [DATA_W-1:0] res_quot_q, res_quot_d, res_rem_q, res_rem_d;
  logic [DATA_W-1:0] a_mag, b_mag, q_fix, r_fix;
  logic accept;

  div_sign_fix u_op_fix (
    .hi_i(div_a), .lo_i(div_b),
    .hi_neg(div_signed & div_a[DATA_W-1]), .lo_neg(div_signed & div_b[DATA_W-1]),
    .hi_o(a_mag), .lo_o(b_mag)
  );

  div_sign_fix u_res_fix (
    .hi_i(dout_tdata[QUOT_MSB:QUOT_LSB]), .lo_i(dout_tdata[REM_MSB:REM_LSB]),
    .hi_neg(q_neg_q), .lo_neg(r_neg_q),
    .hi_o(q_fix), .lo_o(r_fix)
  );

`ifdef DIV_CACHE_EN
  logic              c_vld_q, c_vld_d, c_sgn_q, c_sgn_d, op_sgn_q, op_sgn_d;
  logic [DATA_W-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_q_q, c_q_d, c_r_q, c_r_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              cache_hit;
  assign cache_hit = c_vld_q & (c_sgn_q == div_signed) & (c_a_q == div_a) & (c_b_q == div_b);
`endif

  assign accept        = div_req_valid & div_req_ready;
  assign div_req_ready = (state_q == ST_IDLE) & ~flush;
  assign div_busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    dvd_vld_d  = dvd_vld_q;
    dvs_vld_d  = dvs_vld_q;
    dvd_data_d = dvd_data_q;
    dvs_data_d = dvs_data_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    res_vld_d  = 1'b0;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
`ifdef DIV_CACHE_EN
    c_vld_d = c_vld_q; c_sgn_d = c_sgn_q; c_a_d = c_a_q; c_b_d = c_b_q;
    c_q_d = c_q_q; c_r_d = c_r_q;
    op_sgn_d = op_sgn_q; op_a_d = op_a_q; op_b_d = op_b_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        if (div_b == '0) begin
          res_quot_d = DIV0_QUOT;
          res_rem_d  = div_a;
          state_d    = ST_DONE;
`ifdef DIV_CACHE_EN
        end else if (cache_hit) begin
          res_quot_d = c_q_q;
          res_rem_d  = c_r_q;
          state_d    = ST_DONE;
`endif
        end else begin
          dvd_data_d = a_mag;
          dvs_data_d = b_mag;
          dvd_vld_d  = 1'b1;
          dvs_vld_d  = 1'b1;
          q_neg_d    = div_signed & (div_a[DATA_W-1] ^ div_b[DATA_W-1]);
          r_neg_d    = div_signed & div_a[DATA_W-1];
          state_d    = ST_ISSUE;
`ifdef DIV_CACHE_EN
          op_sgn_d = div_signed; op_a_d = div_a; op_b_d = div_b;
`endif
        end
      end
      ST_ISSUE: begin
        // Channels complete independently; a flush cannot retract a pending tvalid.
        dvd_vld_d = dvd_vld_q & ~dividend_tready;
        dvs_vld_d = dvs_vld_q & ~divisor_tready;
        if (flush) kill_d = 1'b1;
        if (!dvd_vld_d && !dvs_vld_d) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (dout_tvalid) begin
          kill_d = 1'b0;
          if (kill_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            res_quot_d = q_fix;
            res_rem_d  = r_fix;
            state_d    = ST_DONE;
`ifdef DIV_CACHE_EN
            c_vld_d = 1'b1; c_sgn_d = op_sgn_q; c_a_d = op_a_q; c_b_d = op_b_q;
            c_q_d = q_fix; c_r_d = r_fix;
`endif
          end
        end
      end
      ST_DONE: begin
        res_vld_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      kill_q     <= 1'b0;
      dvd_vld_q  <= 1'b0;
      dvs_vld_q  <= 1'b0;
      dvd_data_q <= '0;
      dvs_data_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      res_vld_q  <= 1'b0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      dvd_vld_q  <= dvd_vld_d;
      dvs_vld_q  <= dvs_vld_d;
      dvd_data_q <= dvd_data_d;
      dvs_data_q <= dvs_data_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      res_vld_q  <= res_vld_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
    end
  end

`ifdef DIV_CACHE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_vld_q <= 1'b0; c_sgn_q <= 1'b0; c_a_q <= '0; c_b_q <= '0;
      c_q_q <= '0; c_r_q <= '0;
      op_sgn_q <= 1'b0; op_a_q <= '0; op_b_q <= '0;
    end else begin
      c_vld_q <= c_vld_d; c_sgn_q <= c_sgn_d; c_a_q <= c_a_d; c_b_q <= c_b_d;
      c_q_q <= c_q_d; c_r_q <= c_r_d;
      op_sgn_q <= op_sgn_d; op_a_q <= op_a_d; op_b_q <= op_b_d;
    end
  end
`endif

  assign res_valid       = res_vld_q;
  assign res_quot        = res_quot_q;
  assign res_rem         = res_rem_q;
  assign dividend_tdata  = dvd_data_q;
  assign dividend_tvalid = dvd_vld_q;
  assign divisor_tdata   = dvs_data_q;
  assign divisor_tvalid  = dvs_vld_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: queue-based divider IP model plus an arithmetic reference
// for signed/unsigned quotient and remainder.
module tb_div_ctrl;
  logic        clk, resetn, div_req_valid, div_req_ready, div_signed, flush;
  logic [31:0] div_a, div_b, res_quot, res_rem, dividend_tdata, divisor_tdata;
  logic        div_busy, res_valid, dividend_tvalid, dividend_tready;
  logic        divisor_tvalid, divisor_tready, dout_tvalid;
  logic [63:0] dout_tdata;

  div_ctrl dut (
    .clk(clk), .resetn(resetn), .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
    .div_signed(div_signed), .div_a(div_a), .div_b(div_b), .flush(flush), .div_busy(div_busy),
    .res_valid(res_valid), .res_quot(res_quot), .res_rem(res_rem),
    .dividend_tdata(dividend_tdata), .dividend_tvalid(dividend_tvalid), .dividend_tready(dividend_tready),
    .divisor_tdata(divisor_tdata), .divisor_tvalid(divisor_tvalid), .divisor_tready(divisor_tready),
    .dout_tdata(dout_tdata), .dout_tvalid(dout_tvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] d; } ip_t;
  ip_t         ipq[$];
  logic [31:0] dq_a[$], dq_b[$];
  int          total = 0, bad = 0, cyc = 0, ip_lat = 3, tv_cnt = 0, tv_base = 0;
  int          res_cnt = 0, res_cyc = 0, acc_cyc = 0;
  bit          rdy_rand = 0, acc = 0, s_busy = 0;
  logic [31:0] res_q, res_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  // Observe at negedge, advance one edge, then play the IP for the new cycle.
  task automatic step();
    ip_t e;
    logic [31:0] a, b;
    @(negedge clk);
    s_busy = div_busy;
    if (dividend_tvalid || divisor_tvalid) tv_cnt++;
    if (dividend_tvalid && dividend_tready) dq_a.push_back(dividend_tdata);
    if (divisor_tvalid && divisor_tready) dq_b.push_back(divisor_tdata);
    if (div_req_valid && div_req_ready) begin acc = 1; acc_cyc = cyc; end
    if (res_valid) begin res_cnt++; res_cyc = cyc; res_q = res_quot; res_r = res_rem; end
    @(posedge clk); #1;
    cyc++;
    dout_tvalid = 1'b0;
    if (ipq.size() > 0 && ipq[0].due <= cyc) begin
      dout_tdata = ipq[0].d; dout_tvalid = 1'b1; ipq.delete(0);
    end
    while (dq_a.size() > 0 && dq_b.size() > 0) begin
      a = dq_a.pop_front(); b = dq_b.pop_front();
      e.due = cyc - 1 + ip_lat;
      e.d   = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a / b, a % b};
      ipq.push_back(e);
    end
    if (rdy_rand) begin
      dividend_tready = 1'($urandom); divisor_tready = 1'($urandom);
    end
  endtask

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    div_signed = s; div_a = a; div_b = b; div_req_valid = 1'b1; acc = 0;
    while (!acc && n < 20) begin step(); n++; end
    div_req_valid = 1'b0;
    chk("accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_res(input int base);
    int n = 0;
    while (res_cnt == base && n < 200) begin step(); n++; end
    chk("res_seen", 64'(res_cnt - base), 64'd1);
  endtask

  task automatic do_div(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    int base = res_cnt;
    logic [63:0] e = model(s, a, b);
    tv_base = tv_cnt;
    issue(s, a, b);
    wait_res(base);
    chk({tag, "_q"}, 64'(res_q), 64'(e[63:32]));
    chk({tag, "_r"}, 64'(res_r), 64'(e[31:0]));
    step();
    chk({tag, "_busy"}, 64'(s_busy), 64'd0);
    step();
    chk({tag, "_1pulse"}, 64'(res_cnt - base), 64'd1);
  endtask

  initial begin
    ip_t e;
    logic [31:0] ra, rb, pa, pb;
    bit rs, ps;
    int base, n;
    resetn = 1'b0; div_req_valid = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0;
    flush = 1'b0; dividend_tready = 1'b1; divisor_tready = 1'b1;
    dout_tdata = '0; dout_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(div_busy), 64'd0);
    chk("rst_rv", 64'(res_valid), 64'd0);
    chk("rst_tv", 64'({dividend_tvalid, divisor_tvalid}), 64'd0);
    chk("rst_res", {res_quot, res_rem}, 64'd0);
    chk("rst_td", {dividend_tdata, divisor_tdata}, 64'd0);
    chk("rst_rdy", 64'(div_req_ready), 64'd1);
    resetn = 1'b1;
    step();

    do_div("u100_7", 0, 32'd100, 32'd7);
    do_div("s-7_2", 1, 32'hFFFF_FFF9, 32'd2);
    do_div("smin_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF);

    do_div("div0", 0, 32'd5, 32'd0);
    chk("div0_tv", 64'(tv_cnt - tv_base), 64'd0);
    chk("div0_lat", 64'(res_cyc - acc_cyc), 64'd2);

    // Skewed channel handshakes: dividend at k, divisor at k+3.
    dividend_tready = 1'b0; divisor_tready = 1'b0;
    base = res_cnt;
    issue(1, 32'hFFFF_FC18, 32'd33);
    chk("sk_tv_k", 64'({dividend_tvalid, divisor_tvalid}), 64'd3);
    chk("sk_dd_k", 64'(dividend_tdata), 64'd1000);
    dividend_tready = 1'b1; step(); dividend_tready = 1'b0;
    chk("sk_dvd_low", 64'(dividend_tvalid), 64'd0);
    chk("sk_dvs_k1", 64'({divisor_tvalid, divisor_tdata}), {31'd0, 1'b1, 32'd33});
    step();
    chk("sk_dvs_k2", 64'({divisor_tvalid, divisor_tdata}), {31'd0, 1'b1, 32'd33});
    step();
    chk("sk_dvs_k3", 64'({divisor_tvalid, divisor_tdata}), {31'd0, 1'b1, 32'd33});
    divisor_tready = 1'b1; step(); divisor_tready = 1'b0;
    chk("sk_dvs_low", 64'(divisor_tvalid), 64'd0);
    wait_res(base);
    e.d = model(1, 32'hFFFF_FC18, 32'd33);
    chk("sk_res", {res_q, res_r}, e.d);
    dividend_tready = 1'b1; divisor_tready = 1'b1;
    step();

    // Flush while waiting on the IP: drains, no result.
    ip_lat = 6; base = res_cnt;
    issue(0, 32'd9, 32'd3);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_busy", 64'(div_busy), 64'd1);
    n = 0;
    while (div_busy && n < 50) begin step(); n++; end
    chk("fl_idle", 64'(div_busy), 64'd0);
    chk("fl_drain", 64'(ipq.size()), 64'd0);
    repeat (3) step();
    chk("fl_nores", 64'(res_cnt - base), 64'd0);
    do_div("fl_9_3", 0, 32'd9, 32'd3);
    chk("fl_reissue", 64'(tv_cnt > tv_base), 64'd1);

    // Flush in IDLE only blocks acceptance.
    acc = 0; flush = 1'b1; div_req_valid = 1'b1; div_a = 32'd1; div_b = 32'd1;
    repeat (2) step();
    div_req_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_acc", 64'(acc), 64'd0);

    ip_lat = 3;
    do_div("c1", 0, 32'd100, 32'd7);
    do_div("c2", 0, 32'd100, 32'd7);
`ifdef DIV_CACHE_EN
    chk("c2_tv", 64'(tv_cnt - tv_base), 64'd0);
    chk("c2_lat", 64'(res_cyc - acc_cyc), 64'd2);
`else
    chk("c2_issued", 64'(tv_cnt > tv_base), 64'd1);
`endif

    // Stray IP result in IDLE is ignored.
    base = res_cnt;
    e.due = cyc + 1; e.d = 64'h1234_5678_9ABC_DEF0; ipq.push_back(e);
    repeat (4) step();
    chk("stray_res", 64'(res_cnt - base), 64'd0);
    chk("stray_busy", 64'(div_busy), 64'd0);

    // Reset mid-operation, then a late stray result.
    dividend_tready = 1'b0; divisor_tready = 1'b0;
    issue(1, 32'hFFFF_FF9C, 32'd7);
    resetn = 1'b0; #1;
    chk("mrst_busy", 64'(div_busy), 64'd0);
    chk("mrst_tv", 64'({dividend_tvalid, divisor_tvalid}), 64'd0);
    step(); resetn = 1'b1;
    dq_a.delete(); dq_b.delete();
    dividend_tready = 1'b1; divisor_tready = 1'b1;
    base = res_cnt;
    e.due = cyc + 2; e.d = 64'hDEAD_BEEF_0000_0001; ipq.push_back(e);
    repeat (5) step();
    chk("mrst_stray", 64'(res_cnt - base), 64'd0);
    do_div("mrst_div", 1, 32'hFFFF_FF9C, 32'd7);

    // Randomized requests with random tready and IP latency.
    rdy_rand = 1; ps = 0; pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      ip_lat = $urandom_range(1, 6);
      rs = 1'($urandom);
      ra = $urandom; rb = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 300));
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin rs = 1; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin rs = ps; ra = pa; rb = pb; end
        default: ;
      endcase
      do_div("rnd", rs, ra, rb);
      if (rb == 0) chk("rnd_div0_tv", 64'(tv_cnt - tv_base), 64'd0);
      ps = rs; pa = ra; pb = rb;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
